// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way write-back/write-allocate cache between a 32-bit CPU port and a byte-wide RAM; define CACHE_STATS_EN for hit/miss/writeback counters
module set_assoc_cache #(
    parameter int ADDRESS_WIDTH     = 16,
    parameter int INDEX_WIDTH       = 3,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int WAYS              = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic                     cpu_rd,
    input  logic                     cpu_wr,
    input  logic [31:0]              cpu_wdata,
    input  logic [3:0]               cpu_be,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_ready,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [7:0]               ram_wdata,
    input  logic [7:0]               ram_rdata,
    input  logic                     ram_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
    output logic [31:0]              wb_count
`endif
);
    localparam int TAG_WIDTH  = ADDRESS_WIDTH - INDEX_WIDTH - WORD_OFFSET_WIDTH - 2;
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int LBW        = WORD_OFFSET_WIDTH + 2;
    localparam int LINE_BYTES = 1 << LBW;
    localparam int PW         = (WAYS > 1) ? $clog2(WAYS) : 1;

    if (WAYS != 1 && WAYS != 2 && WAYS != 4) begin : g_bad_ways
        $fatal(1, "set_assoc_cache: WAYS must be 1, 2 or 4");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag
        $fatal(1, "set_assoc_cache: address too narrow for index and offset");
    end

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

    state_t                   r_state, w_next;
    logic [ADDRESS_WIDTH-1:2] r_addr;
    logic [31:0]              r_wdata;
    logic [3:0]               r_be;
    logic                     r_wr;
    logic [PW-1:0]            r_way;
    logic [LBW-1:0]           r_cnt;
    logic [7:0]               r_data  [WAYS][SETS][LINE_BYTES];
    logic [TAG_WIDTH-1:0]     r_tag   [WAYS][SETS];
    logic                     r_valid [WAYS][SETS];
    logic                     r_dirty [WAYS][SETS];
    logic [PW-1:0]            r_rr    [SETS];

    logic [INDEX_WIDTH-1:0]       w_idx;
    logic [TAG_WIDTH-1:0]         w_tag;
    logic [WORD_OFFSET_WIDTH-1:0] w_wo;
    logic                         w_hit, w_evict, w_last, w_ack, w_unused;
    logic [PW-1:0]                w_hit_way, w_vict;
    logic [31:0]                  w_word;

    assign w_idx    = r_addr[LBW +: INDEX_WIDTH];
    assign w_tag    = r_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign w_wo     = r_addr[LBW-1:2];
    assign w_last   = r_cnt == '1;
    assign w_ack    = ram_ack && (r_state == WRITEBACK || r_state == REFILL);
    assign w_unused = &{1'b0, cpu_addr[1:0]};

    // Parallel tag match, victim choice (lowest invalid way, else round-robin) and hit-word mux
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_vict    = r_rr[w_idx];
        w_evict   = 1'b1;
        w_word    = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = PW'(w);
            end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w][w_idx]) begin
                w_vict  = PW'(w);
                w_evict = 1'b0;
            end
        for (int b = 0; b < 4; b++)
            w_word[8*b +: 8] = r_data[w_hit_way][w_idx][{w_wo, 2'(b)}];
    end

    // State register
    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    // Next state and all port outputs, derived from state so reset forces them low
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && (cpu_rd || cpu_wr)) w_next = COMPARE;
        if (r_state == COMPARE)
            w_next = w_hit ? IDLE : (r_valid[w_vict][w_idx] && r_dirty[w_vict][w_idx]) ? WRITEBACK : REFILL;
        if (r_state == WRITEBACK && w_ack && w_last) w_next = REFILL;
        if (r_state == REFILL && w_ack && w_last) w_next = COMPARE;
        cpu_ready = r_state == COMPARE && w_hit;
        cpu_rdata = cpu_ready ? w_word : '0;
        busy      = r_state != IDLE;
        ram_rd    = r_state == REFILL;
        ram_wr    = r_state == WRITEBACK;
        ram_addr  = ram_rd ? {w_tag, w_idx, r_cnt} : ram_wr ? {r_tag[r_way][w_idx], w_idx, r_cnt} : '0;
        ram_wdata = ram_wr ? r_data[r_way][w_idx][r_cnt] : '0;
    end

    // Request capture, line metadata and byte counter; a miss invalidates the victim until refill completes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                end
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
            r_cnt <= '0;
        end else begin
            if (r_state == IDLE && (cpu_rd || cpu_wr)) begin
                r_addr  <= cpu_addr[ADDRESS_WIDTH-1:2];
                r_wdata <= cpu_wdata;
                r_be    <= cpu_be;
                r_wr    <= cpu_wr;
            end
            if (r_state == COMPARE && w_hit && r_wr) r_dirty[w_hit_way][w_idx] <= 1'b1;
            if (r_state == COMPARE && !w_hit) begin
                r_way                  <= w_vict;
                r_cnt                  <= '0;
                r_valid[w_vict][w_idx] <= 1'b0;
                if (w_evict) r_rr[w_idx] <= (r_rr[w_idx] == PW'(WAYS - 1)) ? '0 : r_rr[w_idx] + 1'b1;
            end
            if (w_ack) r_cnt <= r_cnt + 1'b1;
            if (r_state == WRITEBACK && w_ack && w_last) r_dirty[r_way][w_idx] <= 1'b0;
            if (r_state == REFILL && w_ack && w_last) begin
                r_tag[r_way][w_idx]   <= w_tag;
                r_valid[r_way][w_idx] <= 1'b1;
                r_dirty[r_way][w_idx] <= 1'b0;
            end
        end
    end

    // Line storage: refill bytes land on each ack, CPU writes merge into the hit word
    always_ff @(posedge clk) begin
        if (r_state == REFILL && w_ack) r_data[r_way][w_idx][r_cnt] <= ram_rdata;
        if (r_state == COMPARE && w_hit && r_wr)
            for (int b = 0; b < 4; b++)
                if (r_be[b]) r_data[w_hit_way][w_idx][{w_wo, 2'(b)}] <= r_wdata[8*b +: 8];
    end

`ifdef CACHE_STATS_EN
    logic r_refilled;

    // Saturating counters; the hit that closes a refill is not a first-pass hit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refilled <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (r_state == IDLE) r_refilled <= 1'b0;
            if (r_state == REFILL && w_ack && w_last) r_refilled <= 1'b1;
            if (r_state == COMPARE && w_hit && !r_refilled && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (r_state == COMPARE && !w_hit && miss_count != '1) miss_count <= miss_count + 32'd1;
            if (r_state == WRITEBACK && w_ack && w_last && wb_count != '1) wb_count <= wb_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed checks of hit/miss/writeback/refill, reset abort and slow RAM acks
module tb_set_assoc_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, busy, ram_rd, ram_wr;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic        ram_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    set_assoc_cache dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    // RAM model: returns addr[7:0], acks ack_delay cycles after first seeing a request, logs transfers
    int          ack_delay = 1, w_cnt = 0, stab_err = 0, both_err = 0, log_n = 0;
    logic        pend = 1'b0;
    logic [15:0] p_addr;
    logic [7:0]  p_wd;
    logic [15:0] log_addr [512];
    logic        log_wr   [512];
    logic [7:0]  log_wd   [512];

    always @(negedge clk) begin
        if (rst) begin
            ram_ack = 1'b0;
            pend    = 1'b0;
            w_cnt   = 0;
        end else if (ram_ack) begin
            ram_ack = 1'b0;
        end else if (ram_rd || ram_wr) begin
            if (ram_rd && ram_wr) both_err++;
            if (pend && (ram_addr !== p_addr || (ram_wr && ram_wdata !== p_wd))) stab_err++;
            if (!pend) begin
                pend   = 1'b1;
                p_addr = ram_addr;
                p_wd   = ram_wdata;
            end
            if (w_cnt == ack_delay) begin
                ram_ack   = 1'b1;
                ram_rdata = ram_addr[7:0];
                w_cnt     = 0;
                pend      = 1'b0;
                if (log_n < 512) begin
                    log_addr[log_n] = ram_addr;
                    log_wr[log_n]   = ram_wr;
                    log_wd[log_n]   = ram_wdata;
                    log_n++;
                end
            end else begin
                w_cnt++;
            end
        end
    end

    // Number of the 16 logged transfers from base that are not the expected direction/ascending address
    function automatic int log_bad(input int base, input logic wr, input logic [15:0] start);
        int bad = 0;
        for (int i = 0; i < 16; i++)
            if (base + i >= 512 || log_wr[base+i] !== wr || log_addr[base+i] !== start + 16'(i)) bad++;
        return bad;
    endfunction

    task automatic do_req(input logic [15:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata, output int cyc);
        @(negedge clk);
        cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd; cpu_be = be;
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        cyc = 1;
        while (!cpu_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL req_timeout addr=%h: ready=%b want 1", a, cpu_ready); end
        rdata = cpu_rdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", cpu_ready); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if ({ram_rd, ram_wr} !== 2'b00) begin n_bad++; $display("FAIL rst_ram_req: got %b want 00", {ram_rd, ram_wr}); end
        n_cmp++; if (ram_addr !== 16'h0 || ram_wdata !== 8'h0) begin n_bad++; $display("FAIL rst_ram_bus: got %h/%h want 0/0", ram_addr, ram_wdata); end
`ifdef CACHE_STATS_EN
        n_cmp++; if ({hit_count, miss_count, wb_count} !== 96'h0) begin n_bad++; $display("FAIL rst_stats: got %h want 0", {hit_count, miss_count, wb_count}); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_cold_read();
        logic [31:0] rd;
        int cyc, base;
        base = log_n;
        do_req(16'h0040, 1'b1, 1'b0, 32'h0, 4'h0, rd, cyc);
        n_cmp++; if (rd !== 32'h43424140) begin n_bad++; $display("FAIL cold_rdata: got %h want 43424140", rd); end
        n_cmp++; if (log_n - base !== 16) begin n_bad++; $display("FAIL cold_xfers: got %0d want 16", log_n - base); end
        n_cmp++; if (log_bad(base, 1'b0, 16'h0040) !== 0) begin n_bad++; $display("FAIL cold_seq: got %0d bad want 0", log_bad(base, 1'b0, 16'h0040)); end
`ifdef CACHE_STATS_EN
        n_cmp++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin n_bad++; $display("FAIL cold_stats: got m%0d h%0d want m1 h0", miss_count, hit_count); end
`endif
    endtask

    task automatic test_hit_read();
        logic [31:0] rd;
        int cyc, base;
        base = log_n;
        do_req(16'h0044, 1'b1, 1'b0, 32'h0, 4'h0, rd, cyc);
        n_cmp++; if (rd !== 32'h47464544) begin n_bad++; $display("FAIL hit_rdata: got %h want 47464544", rd); end
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL hit_latency: got %0d want 1", cyc); end
        n_cmp++; if (log_n !== base) begin n_bad++; $display("FAIL hit_traffic: got %0d want 0", log_n - base); end
`ifdef CACHE_STATS_EN
        n_cmp++; if (hit_count !== 32'd1) begin n_bad++; $display("FAIL hit_stats: got %0d want 1", hit_count); end
`endif
    endtask

    task automatic test_write_hit();
        logic [31:0] rd;
        int cyc, base;
        base = log_n;
        do_req(16'h0040, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0011, rd, cyc);
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d want 1", cyc); end
        do_req(16'h0040, 1'b1, 1'b0, 32'h0, 4'h0, rd, cyc);
        n_cmp++; if (rd !== 32'h4342BEEF) begin n_bad++; $display("FAIL wr_merge: got %h want 4342beef", rd); end
        n_cmp++; if (log_n !== base) begin n_bad++; $display("FAIL wr_traffic: got %0d want 0", log_n - base); end
    endtask

    task automatic test_writeback();
        logic [31:0] rd;
        int cyc, base, bad;
        logic [7:0] exp;
        base = log_n;
        do_req(16'h00C0, 1'b1, 1'b0, 32'h0, 4'h0, rd, cyc);
        n_cmp++; if (rd !== 32'hC3C2C1C0) begin n_bad++; $display("FAIL fill2_rdata: got %h want c3c2c1c0", rd); end
        n_cmp++; if (log_n - base !== 16 || log_bad(base, 1'b0, 16'h00C0) !== 0) begin n_bad++; $display("FAIL fill2_seq: got %0d xfers want 16 clean reads", log_n - base); end
        base = log_n;
        do_req(16'h0140, 1'b1, 1'b0, 32'h0, 4'h0, rd, cyc);
        n_cmp++; if (log_n - base !== 32) begin n_bad++; $display("FAIL wb_xfers: got %0d want 32", log_n - base); end
        n_cmp++; if (log_bad(base, 1'b1, 16'h0040) !== 0) begin n_bad++; $display("FAIL wb_seq: got %0d bad want 0", log_bad(base, 1'b1, 16'h0040)); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            exp = (i == 0) ? 8'hEF : (i == 1) ? 8'hBE : 8'h40 + 8'(i);
            if (log_wd[base+i] !== exp) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL wb_data: got %0d bad bytes (first %h %h %h %h) want EF BE 42 43", bad, log_wd[base], log_wd[base+1], log_wd[base+2], log_wd[base+3]); end
        n_cmp++; if (log_bad(base + 16, 1'b0, 16'h0140) !== 0) begin n_bad++; $display("FAIL wb_refill_seq: got %0d bad want 0", log_bad(base + 16, 1'b0, 16'h0140)); end
        n_cmp++; if (rd !== 32'h43424140) begin n_bad++; $display("FAIL wb_rdata: got %h want 43424140", rd); end
`ifdef CACHE_STATS_EN
        n_cmp++; if (wb_count !== 32'd1) begin n_bad++; $display("FAIL wb_stats: got %0d want 1", wb_count); end
`endif
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd;
        int cyc, base;
        @(negedge clk);
        cpu_addr = 16'h0040; cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        cyc = 0;
        while (!(ram_rd && ram_addr == 16'h0045) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (!(ram_rd === 1'b1 && ram_addr === 16'h0045)) begin n_bad++; $display("FAIL abort_reach: got rd=%b addr=%h want 1/0045", ram_rd, ram_addr); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_rd !== 1'b0) begin n_bad++; $display("FAIL abort_ram_rd: got %b want 0", ram_rd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (ram_addr !== 16'h0) begin n_bad++; $display("FAIL abort_addr: got %h want 0", ram_addr); end
        rst = 1'b0;
        base = log_n;
        do_req(16'h0040, 1'b1, 1'b0, 32'h0, 4'h0, rd, cyc);
        n_cmp++; if (log_n - base !== 16 || log_bad(base, 1'b0, 16'h0040) !== 0) begin n_bad++; $display("FAIL abort_remiss: got %0d xfers want 16 reads", log_n - base); end
        n_cmp++; if (rd !== 32'h43424140) begin n_bad++; $display("FAIL abort_rdata: got %h want 43424140", rd); end
`ifdef CACHE_STATS_EN
        n_cmp++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin n_bad++; $display("FAIL abort_stats: got m%0d h%0d want m1 h0", miss_count, hit_count); end
`endif
    endtask

    task automatic test_rd_wr_both();
        logic [31:0] rd;
        int cyc, base;
        base = log_n;
        do_req(16'h0048, 1'b1, 1'b1, 32'h12345678, 4'hF, rd, cyc);
        do_req(16'h0048, 1'b1, 1'b0, 32'h0, 4'h0, rd, cyc);
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL rdwr_rdata: got %h want 12345678", rd); end
        n_cmp++; if (log_n !== base) begin n_bad++; $display("FAIL rdwr_traffic: got %0d want 0", log_n - base); end
    endtask

    task automatic test_slow_ack();
        logic [31:0] rd;
        int cyc, base;
        ack_delay = 3;
        base = log_n;
        do_req(16'h0200, 1'b1, 1'b0, 32'h0, 4'h0, rd, cyc);
        n_cmp++; if (rd !== 32'h03020100) begin n_bad++; $display("FAIL slow_rdata: got %h want 03020100", rd); end
        n_cmp++; if (log_n - base !== 16 || log_bad(base, 1'b0, 16'h0200) !== 0) begin n_bad++; $display("FAIL slow_seq: got %0d xfers want 16 reads", log_n - base); end
        n_cmp++; if (cyc < 64) begin n_bad++; $display("FAIL slow_latency: got %0d want >= 64", cyc); end
        n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL ram_stability: got %0d changes want 0", stab_err); end
        n_cmp++; if (both_err !== 0) begin n_bad++; $display("FAIL ram_rd_wr_overlap: got %0d want 0", both_err); end
        ack_delay = 1;
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_hit_read();
        test_write_hit();
        test_writeback();
        test_reset_mid_refill();
        test_rd_wr_both();
        test_slow_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
